// File: rtl/sync_framer.sv
// rtl/sync_framer.sv - transmit framer: 64-bit sync word, then a counted payload, optional output bit slip.
// Optional bit slip (bit_offset port, barrel shift, FLUSH word) is built when SYNC_FRAMER_BITSLIP_EN is defined.
module sync_framer #(
  parameter logic [63:0] PATTERN = 64'hDEADBEEFCAFEBABE,
  parameter int          LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
`ifdef SYNC_FRAMER_BITSLIP_EN
  input  logic [4:0]       bit_offset,
`endif
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [31:0]      data,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, SYNC_HI, SYNC_LO, PAYLOAD, FLUSH} state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = 1;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [4:0]       off_q;
  logic             advance;
  logic [31:0]      cur;
  logic [31:0]      data_nxt;
  logic             last_pay;
  logic             slip;

  assign s_ready  = (state == PAYLOAD);
  assign busy     = (state != IDLE);
  assign last_pay = (cnt + CNT_ONE == len_q);
  assign slip     = (off_q != 5'd0);

  // Logical word for this cycle and whether the output register advances.
  always_comb begin
    advance = 1'b0;
    cur     = 32'h0;
    case (state)
      SYNC_HI: begin
        advance = 1'b1;
        cur     = PATTERN[63:32];
      end
      SYNC_LO: begin
        advance = 1'b1;
        cur     = PATTERN[31:0];
      end
      PAYLOAD: begin
        advance = s_valid;
        cur     = s_data;
      end
      FLUSH: begin
        advance = 1'b1;
        cur     = 32'h0;
      end
      default: begin
        advance = 1'b0;
        cur     = 32'h0;
      end
    endcase
  end

`ifdef SYNC_FRAMER_BITSLIP_EN
  logic [31:0] prev;

  // Low half of {prev, cur} after the slip; FLUSH pushes out the tail of the last word.
  assign data_nxt = 32'({prev, cur} >> off_q);
`else
  assign off_q    = 5'd0;
  assign data_nxt = cur;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      cnt        <= '0;
      data       <= 32'h0;
      data_valid <= 1'b0;
      done       <= 1'b0;
`ifdef SYNC_FRAMER_BITSLIP_EN
      off_q      <= 5'd0;
      prev       <= 32'h0;
`endif
    end else begin
      data_valid <= advance;
      done       <= 1'b0;
      if (advance) begin
        data <= data_nxt;
`ifdef SYNC_FRAMER_BITSLIP_EN
        prev <= cur;
`endif
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= SYNC_HI;
            len_q <= len;
            cnt   <= '0;
`ifdef SYNC_FRAMER_BITSLIP_EN
            off_q <= bit_offset;
            prev  <= 32'h0;
`endif
          end
        end
        SYNC_HI: state <= SYNC_LO;
        SYNC_LO: begin
          if (len_q != '0) begin
            state <= PAYLOAD;
          end else if (slip) begin
            state <= FLUSH;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (s_valid) begin
            cnt <= cnt + CNT_ONE;
            if (last_pay) begin
              if (slip) begin
                state <= FLUSH;
              end else begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_framer.sv
// tb/tb_sync_framer.sv - scoreboard bench for sync_framer with a word-stream reference model.
module tb_sync_framer;

  localparam logic [63:0] PAT = 64'hDEADBEEFCAFEBABE;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [4:0]  bit_offset;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] data;
  logic        data_valid;
  logic        busy;
  logic        done;

  exp_t        exp_q[$];
  logic [31:0] pl[$];
  int          vectors    = 0;
  int          miscompares = 0;
  int          ready_cycles = 0;
  int          busy_cycles  = 0;
  int          done_cnt     = 0;

  sync_framer #(.PATTERN(PAT), .LEN_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
`ifdef SYNC_FRAMER_BITSLIP_EN
    .bit_offset (bit_offset),
`endif
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .data       (data),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Reference: logical stream is sync hi, sync lo, payload, plus a zero tail when slipped.
  task automatic push_frame(input int ln, input int off);
    logic [31:0] lw[$];
    logic [31:0] prev;
    logic [63:0] cat;
    exp_t        e;
    lw.push_back(PAT[63:32]);
    lw.push_back(PAT[31:0]);
    for (int i = 0; i < ln; i++) lw.push_back(pl[i]);
    if (off != 0) lw.push_back(32'h0);
    prev = 32'h0;
    for (int i = 0; i < lw.size(); i++) begin
      cat    = {prev, lw[i]} >> off;
      e.d    = cat[31:0];
      e.last = (i == lw.size() - 1);
      exp_q.push_back(e);
      prev = lw[i];
    end
  endtask

  // Monitor: pops the scoreboard whenever a word is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (s_ready) ready_cycles++;
      if (busy) busy_cycles++;
      if (data_valid) begin
        if (done) done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", data, 32'hxxxxxxxx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word", data, e.d);
          chk("done_flag", {31'h0, done}, {31'h0, e.last});
        end
      end else if (done) begin
        chk("done_without_valid", {31'h0, done}, 32'h0);
      end
    end
  end

  task automatic run_frame(input int ln, input int off, input int pct, input bit gap);
    int idx, guard, gaps, r0, b0, d0;
    bit acc, was_gap;
    push_frame(ln, off);
    r0 = ready_cycles; b0 = busy_cycles; d0 = done_cnt;
    start = 1'b1; len = 8'(ln); bit_offset = 5'(off);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'h0, busy}, 32'h1);
    idx = 0; guard = 0; gaps = 0;
    while (idx < ln && guard < 2000) begin
      s_data  = pl[idx];
      s_valid = (pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= pct);
      was_gap = 1'b0;
      if (gap && idx == 1 && gaps < 2) begin
        s_valid = 1'b0;
        gaps++;
        was_gap = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b1;
        len   = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (was_gap) begin
        chk("gap_valid", {31'h0, data_valid}, 32'h0);
        chk("gap_hold", data, pl[0]);
      end
      if (acc) idx++;
      guard++;
    end
    s_valid = 1'b0;
    if (guard >= 2000) chk("payload_timeout", 32'(idx), 32'(ln));
    guard = 0;
    while (busy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) chk("busy_timeout", {31'h0, busy}, 32'h0);
    @(negedge clk); #1;
    chk("done_count", 32'(done_cnt - d0), 32'h1);
    chk("drained", 32'(exp_q.size()), 32'h0);
    if (pct == 0 && !gap) begin
      chk("ready_cycles", 32'(ready_cycles - r0), 32'(ln));
      chk("busy_cycles", 32'(busy_cycles - b0), 32'(2 + ln + (off != 0 ? 1 : 0)));
    end
  endtask

  initial begin
    int ln, off, pct;
    rst_n = 1'b0; start = 1'b0; len = 8'h0; bit_offset = 5'h0;
    s_valid = 1'b0; s_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data, 32'h0);
    chk("rst_valid", {31'h0, data_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_ready", {31'h0, s_ready}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    pl.delete();
    run_frame(0, 0, 0, 1'b0);
    pl = {32'h11111111, 32'h22222222, 32'h33333333};
    run_frame(3, 0, 0, 1'b0);
    pl = {32'hA5A5A5A5, 32'h5A5A5A5A};
    run_frame(2, 0, 0, 1'b1);
`ifdef SYNC_FRAMER_BITSLIP_EN
    pl.delete();
    run_frame(0, 8, 0, 1'b0);
    for (int o = 0; o < 32; o++) run_frame(0, o, 0, 1'b0);
`endif

    for (int f = 0; f < 30; f++) begin
      ln = $urandom_range(0, 5);
      pl.delete();
      for (int i = 0; i < ln; i++) pl.push_back($urandom);
`ifdef SYNC_FRAMER_BITSLIP_EN
      off = $urandom_range(0, 31);
`else
      off = 0;
`endif
      pct = ($urandom_range(0, 1) == 0) ? 0 : 35;
      run_frame(ln, off, pct, 1'b0);
    end

    // Abort a frame mid-payload; a spurious start while busy must be ignored.
    pl.delete();
    for (int i = 0; i < 4; i++) pl.push_back($urandom);
    push_frame(4, 0);
    start = 1'b1; len = 8'd4; bit_offset = 5'd0; s_valid = 1'b1; s_data = pl[0];
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_payload", {31'h0, s_ready}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_data", data, 32'h0);
    chk("abort_valid", {31'h0, data_valid}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_ready", {31'h0, s_ready}, 32'h0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_abort", {31'h0, busy}, 32'h0);
    pl = {32'hCAFEF00D, 32'h0BADC0DE};
    run_frame(2, 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
